// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1 serial receiver. It delivers correctly framed bytes
// with a one-cycle RxDone pulse and flags a low stop bit with a one-cycle FrameErr pulse.
`default_nettype none

module uart_rx #(
  parameter int CLK_DIV = 27
) (
  input  logic       pClk,
  input  logic       pReset,
  input  logic       Rx,
  output logic [7:0] RxData,
  output logic       RxDone,
  output logic       FrameErr,
  output logic       RxBusy
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state;
  state_t             next_state;
  logic               rx_m;
  logic               rx_s;
  logic               rx_d;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [3:0]         os_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shift;
  logic               full_bit;

  // Synchroniser and history flop preset high so reset can never look like a start edge.
  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= Rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign tick     = (state != IDLE) && (div_cnt == DIV_MAX);
  assign full_bit = tick && (os_cnt == 4'd15);
  assign RxBusy   = (state != IDLE);

  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (rx_d && !rx_s) next_state = START;
      START: if (tick && (os_cnt == 4'd7)) next_state = rx_s ? IDLE : DATA;
      DATA:  if (full_bit && (bit_cnt == 3'd7)) next_state = STOP;
      STOP:  if (full_bit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Divider held in IDLE so the oversample phase is aligned to the start edge.
  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      div_cnt <= '0;
      os_cnt  <= 4'd0;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
    end else begin
      if (state == IDLE || div_cnt == DIV_MAX) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (state != next_state) begin
        os_cnt <= 4'd0;
      end else if (tick) begin
        os_cnt <= os_cnt + 4'd1;
      end

      if (state != DATA) begin
        bit_cnt <= 3'd0;
      end else if (full_bit) begin
        bit_cnt <= bit_cnt + 3'd1;
        shift   <= {rx_s, shift[7:1]};
      end
    end
  end

  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      RxData   <= 8'h00;
      RxDone   <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      RxDone   <= 1'b0;
      FrameErr <= 1'b0;
      if (state == STOP && full_bit) begin
        if (rx_s) begin
          RxData <= shift;
          RxDone <= 1'b1;
        end else begin
          FrameErr <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed stimulus for uart_rx at CLK_DIV=4. Expected bytes are queued
// when a frame is sent and are compared when RxDone pulses.
`default_nettype none

module tb_uart_rx;

  localparam int CLK_DIV = 4;
  localparam int BIT     = 16 * CLK_DIV;

  logic       pClk;
  logic       pReset;
  logic       Rx;
  logic [7:0] RxData;
  logic       RxDone;
  logic       FrameErr;
  logic       RxBusy;

  int         checks;
  int         errors;
  int         cyc;
  int         done_cnt;
  int         ferr_cnt;
  logic [7:0] prev_data;
  logic [7:0] exp_q[$];
  int         done_cyc[$];

  uart_rx #(.CLK_DIV(CLK_DIV)) dut (
    .pClk     (pClk),
    .pReset   (pReset),
    .Rx       (Rx),
    .RxData   (RxData),
    .RxDone   (RxDone),
    .FrameErr (FrameErr),
    .RxBusy   (RxBusy)
  );

  initial pClk = 1'b0;
  always #5 pClk = ~pClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on RxDone and checks RxData holds otherwise.
  always @(negedge pClk) begin
    logic [7:0] exp;
    cyc++;
    if (!pReset) begin
      if (RxDone) begin
        done_cnt++;
        done_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_rxdone", 32'd1, 32'd0);
        end else begin
          exp = exp_q.pop_front();
          check("rxdata", {24'd0, RxData}, {24'd0, exp});
        end
        check("busy_on_done", {31'd0, RxBusy}, 32'd0);
        check("done_ferr_excl", {31'd0, FrameErr}, 32'd0);
      end else begin
        check("rxdata_hold", {24'd0, RxData}, {24'd0, prev_data});
      end
      if (FrameErr) ferr_cnt++;
    end
    prev_data = RxData;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    Rx = 1'b0;
    repeat (BIT) @(negedge pClk);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      repeat (BIT) @(negedge pClk);
    end
    Rx = stop;
    repeat (BIT) @(negedge pClk);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 2000 && done_cnt < target; i++) @(negedge pClk);
    check("done_count", done_cnt, target);
  endtask

  initial begin
    int busy_len;
    int d0;
    int f0;
    int base;
    int gap;
    checks = 0; errors = 0; cyc = 0; done_cnt = 0; ferr_cnt = 0;
    prev_data = 8'h00;
    pReset = 1'b1;
    Rx = 1'b1;

    // Reset with a toggling line
    for (int i = 0; i < 20; i++) begin
      @(negedge pClk);
      Rx = 1'($urandom_range(0, 1));
    end
    check("rst_rxdata", {24'd0, RxData}, 32'h00);
    check("rst_rxdone", {31'd0, RxDone}, 32'd0);
    check("rst_frameerr", {31'd0, FrameErr}, 32'd0);
    check("rst_rxbusy", {31'd0, RxBusy}, 32'd0);
    Rx = 1'b1;
    @(negedge pClk);
    pReset = 1'b0;
    busy_len = 0;
    repeat (200) begin
      @(negedge pClk);
      if (RxBusy) busy_len++;
    end
    check("idle_no_done", done_cnt, 0);
    check("idle_no_ferr", ferr_cnt, 0);
    check("idle_no_busy", busy_len, 0);

    // Good frame 0xA5
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_done(1);
    check("a5_no_ferr", ferr_cnt, 0);

    // 16-cycle glitch
    busy_len = 0;
    Rx = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge pClk);
      if (i == 15) Rx = 1'b1;
      if (RxBusy) busy_len++;
    end
    check("glitch_busy_seen", {31'd0, busy_len > 0}, 32'd1);
    check("glitch_busy_max", {31'd0, busy_len <= 40}, 32'd1);
    check("glitch_no_done", done_cnt, 1);
    check("glitch_no_ferr", ferr_cnt, 0);
    check("glitch_rxdata", {24'd0, RxData}, 32'hA5);

    // Framing error followed by a held-low line
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    busy_len = 0;
    repeat (300) begin
      @(negedge pClk);
      if (RxBusy) busy_len++;
    end
    check("break_no_busy", busy_len, 0);
    check("ferr_count", ferr_cnt, f0 + 1);
    check("ferr_no_done", done_cnt, d0);
    check("ferr_rxdata", {24'd0, RxData}, 32'hA5);
    Rx = 1'b1;
    repeat (BIT) @(negedge pClk);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_done(d0 + 1);

    // Back-to-back frames with no idle bits
    repeat (BIT) @(negedge pClk);
    base = done_cyc.size();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_done(done_cnt + ((done_cyc.size() - base) >= 2 ? 0 : 2 - (done_cyc.size() - base)));
    if (done_cyc.size() >= base + 2) begin
      gap = done_cyc[base + 1] - done_cyc[base];
      check("b2b_gap_lo", {31'd0, gap >= 638}, 32'd1);
      check("b2b_gap_hi", {31'd0, gap <= 642}, 32'd1);
    end else begin
      check("b2b_pulses", done_cyc.size() - base, 2);
    end

    // Reset during data bit 4, then a clean 0x55
    d0 = done_cnt;
    f0 = ferr_cnt;
    Rx = 1'b0;
    repeat (BIT) @(negedge pClk);
    for (int i = 0; i < 4; i++) begin
      Rx = i[0];
      repeat (BIT) @(negedge pClk);
    end
    Rx = 1'b1;
    repeat (BIT / 2) @(negedge pClk);
    pReset = 1'b1;
    repeat (3) @(negedge pClk);
    check("abort_rxdata", {24'd0, RxData}, 32'h00);
    check("abort_rxbusy", {31'd0, RxBusy}, 32'd0);
    check("abort_rxdone", {31'd0, RxDone}, 32'd0);
    check("abort_frameerr", {31'd0, FrameErr}, 32'd0);
    repeat (7) @(negedge pClk);
    pReset = 1'b0;
    repeat (200) @(negedge pClk);
    check("abort_no_done", done_cnt, d0);
    check("abort_no_ferr", ferr_cnt, f0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    wait_done(d0 + 1);
    check("final_rxdata", {24'd0, RxData}, 32'h55);

    repeat (20) @(negedge pClk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial receive front-end of the UART. It samples the asynchronous `Rx` line with 16x oversampling and deserialises 8N1 frames (LSB first). Each good byte is presented on `RxData` with a one-cycle `RxDone` pulse, and it feeds the UART register block's `RxDone`/`RxData` inputs directly. Framing errors are flagged and never delivered as data.

## Interface
Parameters:
- `CLK_DIV`, default 27: pClk cycles per oversample tick. The bit period is 16*CLK_DIV cycles. Legal range is ≥ 2. 27 gives ≈115200 baud at 50 MHz.

Ports:
- `pClk`  in  1  system clock; all logic is on the rising edge
- `pReset`  in  1  asynchronous, active-high reset
- `Rx`  in  1  serial line; asynchronous to pClk; idles high
- `RxData`  out  8  last correctly framed byte
- `RxDone`  out  1  one-cycle pulse when RxData is updated
- `FrameErr`  out  1  one-cycle pulse when the stop bit is sampled low
- `RxBusy`  out  1  high whenever the FSM is not in IDLE

## Operation
- **Synchroniser:** two flops, `Rx` → `rx_s`, plus one history flop `rx_d`. All three reset to 1 so reset cannot produce a false start.
- **Tick divider:** counter runs 0..CLK_DIV-1. `tick` is asserted when it equals CLK_DIV-1. The counter is held at 0 in IDLE, so divider phase aligns to the start edge.
- **Oversample counter** `os_cnt` (4 bit): counts ticks and is cleared on every state change.
- **Bit counter** `bit_cnt` (3 bit): counts data bits.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: goes to START on a falling edge (`rx_d`==1 && `rx_s`==0). A line that is merely low, e.g. a break after a framing error, never starts a frame.
  - START: on the 8th tick (mid start bit), if `rx_s`==0 go to DATA; otherwise this was a glitch, go back to IDLE.
  - DATA: on every 16th tick, shift = {`rx_s`, shift[7:1]}. After the 8th bit (`bit_cnt`==7), go to STOP.
  - STOP: on the 16th tick, sample `rx_s`.
    - If 1: RxData ← shift, pulse RxDone.
    - If 0: pulse FrameErr; RxData is unchanged.
    - Either way, go to IDLE.
- **Output rules:**
  - RxDone and FrameErr are mutually exclusive and last exactly one cycle.
  - RxData changes only on the RxDone cycle and holds its value otherwise.
- **Back-to-back frames:** IDLE is re-entered at mid stop bit, so a start edge up to half a bit later is accepted with no idle gap required.
- **Reset mid-frame:** immediately returns to IDLE and clears all counters and the shift register. Outputs take their reset values.

## Timing
- **Reset values:** RxData=0x00, RxDone=0, FrameErr=0, RxBusy=0. FSM=IDLE, counters=0.
- **Input latency:** 2 cycles from the `Rx` pin to `rx_s`.
- **RxBusy** rises the cycle after the falling edge is seen on `rx_s`/`rx_d`.
- **Sample points**, measured in ticks after entering START:
  - start-bit check at tick 8
  - data bit k (k = 0..7) at tick 8+16*(k+1)
  - stop bit at tick 152
- **RxDone/FrameErr** are registered. They are high in the cycle after the stop-sample tick, and RxBusy is 0 in that same cycle.
- **Total latency:** ≈ 152*CLK_DIV + 3 cycles from the start edge on the `Rx` pin to RxDone, ±1 cycle depending on edge alignment.
- **Clock tolerance:** mid-bit sampling tolerates ±3% baud mismatch over a frame.

## Test plan
All scenarios use CLK_DIV=4, so a bit is 64 cycles.
- Assert pReset with `Rx` toggling → RxData=0x00; RxDone, FrameErr and RxBusy all 0; no pulses for 200 cycles after release with `Rx`=1.
- Send 0xA5 as 8N1 → exactly one RxDone pulse, RxData=0xA5, FrameErr never high, RxBusy low on the RxDone cycle.
- Drive `Rx` low for 16 cycles, then high (glitch) → RxBusy high for ≤ 40 cycles then low; no RxDone or FrameErr; RxData keeps its previous value.
- Send 0x3C with the stop bit low, hold `Rx` low for 300 cycles, then release → one FrameErr pulse, no RxDone, RxData still 0xA5, RxBusy stays 0 during the held-low period. A following 0x5A frame is received correctly.
- Send 0x00 and then 0xFF back-to-back with no idle bits → two RxDone pulses, 640 ± 2 cycles apart, with RxData 0x00 then 0xFF.
- Assert pReset during data bit 4 of a frame, release it, then send 0x55 → all outputs cleared during reset, no pulse from the aborted frame, then RxDone with RxData=0x55.
